// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with load-use stall and flush bubbles (optional counters: ID_EX_STALL_CNT_EN)
module id_ex_pipe_reg #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          valid_i,
  input  logic          flush_i,
  input  logic          RegWrite_i,
  input  logic [4:0]    ALU_op_i,
  input  logic          ALUSrc_i,
  input  logic [1:0]    RegDst_i,
  input  logic          Branch_i,
  input  logic [2:0]    BranchType_i,
  input  logic          Jump_i,
  input  logic          MemRead_i,
  input  logic          MemWrite_i,
  input  logic [1:0]    MemtoReg_i,
  input  logic          jal_i,
  input  logic [DW-1:0] pc4_i,
  input  logic [DW-1:0] rs_data_i,
  input  logic [DW-1:0] rt_data_i,
  input  logic [DW-1:0] imm_i,
  input  logic [AW-1:0] rs_addr_i,
  input  logic [AW-1:0] rt_addr_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic          valid_o,
  output logic          flush_o,
  output logic          RegWrite_o,
  output logic [4:0]    ALU_op_o,
  output logic          ALUSrc_o,
  output logic [1:0]    RegDst_o,
  output logic          Branch_o,
  output logic [2:0]    BranchType_o,
  output logic          Jump_o,
  output logic          MemRead_o,
  output logic          MemWrite_o,
  output logic [1:0]    MemtoReg_o,
  output logic          jal_o,
  output logic [DW-1:0] pc4_o,
  output logic [DW-1:0] rs_data_o,
  output logic [DW-1:0] rt_data_o,
  output logic [DW-1:0] imm_o,
  output logic [AW-1:0] rs_addr_o,
  output logic [AW-1:0] rt_addr_o,
  output logic [AW-1:0] rd_addr_o,
`ifdef ID_EX_STALL_CNT_EN
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
`endif
  output logic          stall_o
);

  logic rt_match;
  logic bubble;
  logic ctrl_kill;

  // EX holds a load whose destination is read by the ID instruction
  assign rt_match  = (rt_addr_o == rs_addr_i) | (rt_addr_o == rt_addr_i);
  assign stall_o   = valid_i & ~flush_i & valid_o & MemRead_o & (rt_addr_o != '0) & rt_match;
  assign bubble    = flush_i | stall_o;
  assign ctrl_kill = bubble | ~valid_i;

  // Control fields: zero on any bubble or when ID has no real instruction
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o      <= 1'b0;
      flush_o      <= 1'b0;
      RegWrite_o   <= 1'b0;
      ALU_op_o     <= '0;
      ALUSrc_o     <= 1'b0;
      RegDst_o     <= '0;
      Branch_o     <= 1'b0;
      BranchType_o <= '0;
      Jump_o       <= 1'b0;
      MemRead_o    <= 1'b0;
      MemWrite_o   <= 1'b0;
      MemtoReg_o   <= '0;
      jal_o        <= 1'b0;
    end else if (ctrl_kill) begin
      valid_o      <= bubble ? 1'b0 : valid_i;
      flush_o      <= 1'b0;
      RegWrite_o   <= 1'b0;
      ALU_op_o     <= '0;
      ALUSrc_o     <= 1'b0;
      RegDst_o     <= '0;
      Branch_o     <= 1'b0;
      BranchType_o <= '0;
      Jump_o       <= 1'b0;
      MemRead_o    <= 1'b0;
      MemWrite_o   <= 1'b0;
      MemtoReg_o   <= '0;
      jal_o        <= 1'b0;
    end else begin
      valid_o      <= valid_i;
      flush_o      <= flush_i;
      RegWrite_o   <= RegWrite_i;
      ALU_op_o     <= ALU_op_i;
      ALUSrc_o     <= ALUSrc_i;
      RegDst_o     <= RegDst_i;
      Branch_o     <= Branch_i;
      BranchType_o <= BranchType_i;
      Jump_o       <= Jump_i;
      MemRead_o    <= MemRead_i;
      MemWrite_o   <= MemWrite_i;
      MemtoReg_o   <= MemtoReg_i;
      jal_o        <= jal_i;
    end
  end

  // Data/address fields: cleared on flush, held on load-use stall, else captured
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc4_o     <= '0;
      rs_data_o <= '0;
      rt_data_o <= '0;
      imm_o     <= '0;
      rs_addr_o <= '0;
      rt_addr_o <= '0;
      rd_addr_o <= '0;
    end else if (flush_i) begin
      pc4_o     <= '0;
      rs_data_o <= '0;
      rt_data_o <= '0;
      imm_o     <= '0;
      rs_addr_o <= '0;
      rt_addr_o <= '0;
      rd_addr_o <= '0;
    end else if (!stall_o) begin
      pc4_o     <= pc4_i;
      rs_data_o <= rs_data_i;
      rt_data_o <= rt_data_i;
      imm_o     <= imm_i;
      rs_addr_o <= rs_addr_i;
      rt_addr_o <= rt_addr_i;
      rd_addr_o <= rd_addr_i;
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  // Saturating bubble counters, split by cause
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_o && (stall_cnt_o != {CNT_W{1'b1}}))
        stall_cnt_o <= stall_cnt_o + 1'b1;
      if (flush_i && (flush_cnt_o != {CNT_W{1'b1}}))
        flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - directed self-checking bench for id_ex_pipe_reg
module tb_id_ex_pipe_reg;
  localparam int DW = 32;
  localparam int AW = 5;
`ifdef ID_EX_STALL_CNT_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif

  logic clk_i = 1'b0;
  logic rst_i;
  logic valid_i, flush_i, RegWrite_i, ALUSrc_i, Branch_i, Jump_i, MemRead_i, MemWrite_i, jal_i;
  logic [4:0] ALU_op_i;
  logic [1:0] RegDst_i, MemtoReg_i;
  logic [2:0] BranchType_i;
  logic [DW-1:0] pc4_i, rs_data_i, rt_data_i, imm_i;
  logic [AW-1:0] rs_addr_i, rt_addr_i, rd_addr_i;
  logic valid_o, flush_o, RegWrite_o, ALUSrc_o, Branch_o, Jump_o, MemRead_o, MemWrite_o, jal_o, stall_o;
  logic [4:0] ALU_op_o;
  logic [1:0] RegDst_o, MemtoReg_o;
  logic [2:0] BranchType_o;
  logic [DW-1:0] pc4_o, rs_data_o, rt_data_o, imm_o;
  logic [AW-1:0] rs_addr_o, rt_addr_o, rd_addr_o;
`ifdef ID_EX_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  id_ex_pipe_reg #(.DW(DW), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .flush_i(flush_i),
    .RegWrite_i(RegWrite_i), .ALU_op_i(ALU_op_i), .ALUSrc_i(ALUSrc_i), .RegDst_i(RegDst_i),
    .Branch_i(Branch_i), .BranchType_i(BranchType_i), .Jump_i(Jump_i), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .MemtoReg_i(MemtoReg_i), .jal_i(jal_i), .pc4_i(pc4_i),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i), .rs_addr_i(rs_addr_i),
    .rt_addr_i(rt_addr_i), .rd_addr_i(rd_addr_i),
    .valid_o(valid_o), .flush_o(flush_o), .RegWrite_o(RegWrite_o), .ALU_op_o(ALU_op_o),
    .ALUSrc_o(ALUSrc_o), .RegDst_o(RegDst_o), .Branch_o(Branch_o), .BranchType_o(BranchType_o),
    .Jump_o(Jump_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .MemtoReg_o(MemtoReg_o),
    .jal_o(jal_o), .pc4_o(pc4_o), .rs_data_o(rs_data_o), .rt_data_o(rt_data_o), .imm_o(imm_o),
    .rs_addr_o(rs_addr_o), .rt_addr_o(rt_addr_o), .rd_addr_o(rd_addr_o),
`ifdef ID_EX_STALL_CNT_EN
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o),
`endif
    .stall_o(stall_o)
  );

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    valid_i = 0; flush_i = 0; RegWrite_i = 0; ALU_op_i = 0; ALUSrc_i = 0; RegDst_i = 0;
    Branch_i = 0; BranchType_i = 0; Jump_i = 0; MemRead_i = 0; MemWrite_i = 0; MemtoReg_i = 0;
    jal_i = 0; pc4_i = 0; rs_data_i = 0; rt_data_i = 0; imm_i = 0;
    rs_addr_i = 0; rt_addr_i = 0; rd_addr_i = 0;
  endtask

  // lw $rt, 0($rs)
  task automatic drive_lw(input logic [AW-1:0] rt);
    clear_inputs();
    valid_i = 1; RegWrite_i = 1; ALUSrc_i = 1; MemRead_i = 1; MemtoReg_i = 2'd1;
    pc4_i = 32'h0000_0040; rs_data_i = 32'h0000_1000; rs_addr_i = 5'd29; rt_addr_i = rt;
  endtask

  // add $rd, $rs, $rt
  task automatic drive_add(input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] rd);
    clear_inputs();
    valid_i = 1; RegWrite_i = 1; ALU_op_i = 5'd2; RegDst_i = 2'd1;
    pc4_i = 32'h0000_0044; rs_data_i = 32'hAAAA_0001; rt_data_i = 32'h0000_0007;
    rs_addr_i = rs; rt_addr_i = rt; rd_addr_i = rd;
  endtask

  task automatic test_reset();
    clear_inputs();
    valid_i = 1; RegWrite_i = 1; ALU_op_i = 5'd3; MemWrite_i = 1; pc4_i = 32'h10;
    rs_data_i = 32'hDEAD_BEEF; rt_addr_i = 5'd7;
    tick();
    #2 rst_i = 1;
    #1;
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b want 0", valid_o); end
    n_cmp++; if (RegWrite_o !== 1'b0 || ALU_op_o !== 5'd0 || MemWrite_o !== 1'b0) begin n_bad++;
      $display("FAIL reset_ctrl got %0b/%0d/%0b want 0/0/0", RegWrite_o, ALU_op_o, MemWrite_o); end
    n_cmp++; if (rs_data_o !== 32'h0 || pc4_o !== 32'h0 || rt_addr_o !== 5'd0) begin n_bad++;
      $display("FAIL reset_data got %h/%h/%0d want 0/0/0", rs_data_o, pc4_o, rt_addr_o); end
    n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %0b want 0", stall_o); end
    #1 rst_i = 0;
    tick();
    n_cmp++; if (valid_o !== 1'b1 || rs_data_o !== 32'hDEAD_BEEF || ALU_op_o !== 5'd3) begin n_bad++;
      $display("FAIL reset_release_capture got %0b/%h/%0d want 1/deadbeef/3", valid_o, rs_data_o, ALU_op_o); end
  endtask

  task automatic test_passthrough();
    clear_inputs();
    valid_i = 1; RegWrite_i = 1; ALUSrc_i = 1; ALU_op_i = 5'd0;
    pc4_i = 32'h0000_0100; rs_data_i = 32'h0000_1234; rt_data_i = 32'h55; imm_i = 32'hFFFF_FFFC;
    rs_addr_i = 5'd3; rt_addr_i = 5'd4; rd_addr_i = 5'd0;
    tick();
    n_cmp++; if (valid_o !== 1'b1 || RegWrite_o !== 1'b1 || ALUSrc_o !== 1'b1 || ALU_op_o !== 5'd0) begin n_bad++;
      $display("FAIL addi_ctrl got v%0b rw%0b src%0b op%0d want 1/1/1/0", valid_o, RegWrite_o, ALUSrc_o, ALU_op_o); end
    n_cmp++; if (rs_data_o !== 32'h0000_1234 || imm_o !== 32'hFFFF_FFFC || pc4_o !== 32'h100 || rt_data_o !== 32'h55) begin n_bad++;
      $display("FAIL addi_data got %h/%h/%h/%h want 1234/fffffffc/100/55", rs_data_o, imm_o, pc4_o, rt_data_o); end
    n_cmp++; if (rs_addr_o !== 5'd3 || rt_addr_o !== 5'd4) begin n_bad++;
      $display("FAIL addi_addr got %0d/%0d want 3/4", rs_addr_o, rt_addr_o); end
    // branch/jal fields pass through
    clear_inputs();
    valid_i = 1; Branch_i = 1; BranchType_i = 3'd5; Jump_i = 1; jal_i = 1; RegDst_i = 2'd2; MemtoReg_i = 2'd2;
    tick();
    n_cmp++; if (Branch_o !== 1'b1 || BranchType_o !== 3'd5 || Jump_o !== 1'b1 || jal_o !== 1'b1 || RegDst_o !== 2'd2 || MemtoReg_o !== 2'd2) begin n_bad++;
      $display("FAIL branch_fields got %0b/%0d/%0b/%0b/%0d/%0d want 1/5/1/1/2/2", Branch_o, BranchType_o, Jump_o, jal_o, RegDst_o, MemtoReg_o); end
    // invalid slot: control zeroed, data still captured
    clear_inputs();
    RegWrite_i = 1; MemWrite_i = 1; rs_data_i = 32'h0BAD_F00D;
    tick();
    n_cmp++; if (valid_o !== 1'b0 || RegWrite_o !== 1'b0 || MemWrite_o !== 1'b0 || rs_data_o !== 32'h0BAD_F00D) begin n_bad++;
      $display("FAIL invalid_slot got %0b/%0b/%0b/%h want 0/0/0/0badf00d", valid_o, RegWrite_o, MemWrite_o, rs_data_o); end
  endtask

  task automatic test_load_use();
    drive_lw(5'd8);
    tick();
    drive_add(5'd8, 5'd9, 5'd10);
    #1;
    n_cmp++; if (stall_o !== 1'b1) begin n_bad++; $display("FAIL lu_stall got %0b want 1", stall_o); end
    tick();
    n_cmp++; if (RegWrite_o !== 1'b0 || valid_o !== 1'b0 || MemRead_o !== 1'b0) begin n_bad++;
      $display("FAIL lu_bubble got %0b/%0b/%0b want 0/0/0", RegWrite_o, valid_o, MemRead_o); end
    n_cmp++; if (rt_addr_o !== 5'd8 || rs_data_o !== 32'h0000_1000) begin n_bad++;
      $display("FAIL lu_hold got %0d/%h want 8/00001000", rt_addr_o, rs_data_o); end
    n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL lu_stall_clear got %0b want 0", stall_o); end
`ifdef ID_EX_STALL_CNT_EN
    n_cmp++; if (stall_cnt_o !== 4'd1) begin n_bad++; $display("FAIL lu_stall_cnt got %0d want 1", stall_cnt_o); end
`endif
    tick();
    n_cmp++; if (valid_o !== 1'b1 || rd_addr_o !== 5'd10 || rs_addr_o !== 5'd8 || ALU_op_o !== 5'd2 || rs_data_o !== 32'hAAAA_0001) begin n_bad++;
      $display("FAIL lu_add_capture got %0b/%0d/%0d/%0d/%h want 1/10/8/2/aaaa0001", valid_o, rd_addr_o, rs_addr_o, ALU_op_o, rs_data_o); end
  endtask

  task automatic test_no_false_stall();
    drive_lw(5'd0);
    tick();
    drive_add(5'd0, 5'd0, 5'd11);
    #1;
    n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL nf_zero_reg got %0b want 0", stall_o); end
    drive_lw(5'd8);
    tick();
    drive_add(5'd9, 5'd10, 5'd12);
    #1;
    n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL nf_other_regs got %0b want 0", stall_o); end
    // hazard via rt match
    drive_add(5'd9, 5'd8, 5'd12);
    #1;
    n_cmp++; if (stall_o !== 1'b1) begin n_bad++; $display("FAIL nf_rt_match got %0b want 1", stall_o); end
    // same match but ID slot not valid
    valid_i = 0;
    #1;
    n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL nf_invalid_id got %0b want 0", stall_o); end
    tick();
  endtask

  task automatic test_flush_hazard();
    drive_lw(5'd8);
    tick();
    drive_add(5'd8, 5'd9, 5'd10);
    flush_i = 1;
    #1;
    n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL fl_stall got %0b want 0", stall_o); end
    tick();
    n_cmp++; if (valid_o !== 1'b0 || RegWrite_o !== 1'b0 || MemRead_o !== 1'b0 || MemtoReg_o !== 2'd0 || ALU_op_o !== 5'd0) begin n_bad++;
      $display("FAIL fl_ctrl got %0b/%0b/%0b/%0d/%0d want 0", valid_o, RegWrite_o, MemRead_o, MemtoReg_o, ALU_op_o); end
    n_cmp++; if (rs_data_o !== 32'h0 || rt_addr_o !== 5'd0 || pc4_o !== 32'h0) begin n_bad++;
      $display("FAIL fl_data got %h/%0d/%h want 0/0/0", rs_data_o, rt_addr_o, pc4_o); end
`ifdef ID_EX_STALL_CNT_EN
    n_cmp++; if (flush_cnt_o !== 4'd1 || stall_cnt_o !== 4'd1) begin n_bad++;
      $display("FAIL fl_cnt got flush %0d stall %0d want 1/1", flush_cnt_o, stall_cnt_o); end
`endif
    clear_inputs();
    tick();
  endtask

`ifdef ID_EX_STALL_CNT_EN
  task automatic test_saturation();
    for (int i = 0; i < 17; i++) begin
      drive_lw(5'd8);
      tick();
      drive_add(5'd8, 5'd9, 5'd10);
      tick();
    end
    n_cmp++; if (stall_cnt_o !== 4'hF) begin n_bad++; $display("FAIL sat_stall_cnt got %0h want f", stall_cnt_o); end
    n_cmp++; if (flush_cnt_o !== 4'd1) begin n_bad++; $display("FAIL sat_flush_cnt got %0d want 1", flush_cnt_o); end
  endtask
`endif

  initial begin
    clear_inputs();
    rst_i = 1;
    repeat (2) tick();
    rst_i = 0;
    test_reset();
    test_passthrough();
    test_load_use();
    test_no_false_stall();
    test_flush_hazard();
`ifdef ID_EX_STALL_CNT_EN
    test_saturation();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
